// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS inter-stage registers: per-boundary payload
// widths, control field positions, bubble kill masks and the slot operation codes.
package pipe_pkg;

  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 128;
  localparam int IDEX_CTRL_W  = 20;
  localparam int EXMEM_DATA_W = 106;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 4;

  // ID/EX control field bit positions; later stages keep the low fields in the same order
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_PC_SRC     = 4;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_REG_DST    = 7;
  localparam int CTRL_ALU_OP_LSB = 8;
  localparam int CTRL_ALU_OP_W   = 4;

  localparam logic [IFID_CTRL_W-1:0]  IFID_KILL_MASK  = 1'b1;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_KILL_MASK  =
    IDEX_CTRL_W'((1 << CTRL_REG_WRITE) | (1 << CTRL_MEM_READ) | (1 << CTRL_MEM_WRITE) |
                 (1 << CTRL_BRANCH) | (1 << CTRL_PC_SRC));
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_KILL_MASK =
    EXMEM_CTRL_W'((1 << CTRL_REG_WRITE) | (1 << CTRL_MEM_READ) | (1 << CTRL_MEM_WRITE) |
                  (1 << CTRL_BRANCH));
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_KILL_MASK = MEMWB_CTRL_W'(1 << CTRL_REG_WRITE);

  typedef enum logic [2:0] {
    SLOT_HOLD  = 3'd0,
    SLOT_CLEAR = 3'd1,
    SLOT_LOAD  = 3'd2,
    SLOT_KILL  = 3'd3,
    SLOT_DROP  = 3'd4
  } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry register (valid + data + ctrl + bubble flag) driven by a
// single operation code each cycle.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                CTRL_W    = 20,
  parameter logic [CTRL_W-1:0] KILL_MASK = '1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  slot_op_e          op,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic              ld_bubble,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic              bubble
);

  // KILL re-emits the held payload with its hazardous control bits cleared
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid  <= 1'b0;
      data   <= '0;
      ctrl   <= '0;
      bubble <= 1'b0;
    end else begin
      case (op)
        SLOT_CLEAR: begin
          valid  <= 1'b0;
          data   <= '0;
          ctrl   <= '0;
          bubble <= 1'b0;
        end
        SLOT_LOAD: begin
          valid  <= 1'b1;
          data   <= ld_data;
          ctrl   <= ld_ctrl;
          bubble <= ld_bubble;
        end
        SLOT_KILL: begin
          valid  <= 1'b1;
          ctrl   <= ctrl & ~KILL_MASK;
          bubble <= 1'b1;
        end
        SLOT_DROP: begin
          valid  <= 1'b0;
          bubble <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush and bubble insertion.
// Define PIPE_REG_SKID_EN to add a second (skid) slot that registers the ready path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                CTRL_W    = 20,
  parameter logic [CTRL_W-1:0] KILL_MASK = '1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_bubble
);

  logic              advance;
  logic              in_fire;
  slot_op_e          main_op;
  logic [DATA_W-1:0] main_ld_data;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic              main_ld_bubble;

  assign advance = !out_valid | out_ready;
  assign in_fire = in_valid & in_ready;

`ifdef PIPE_REG_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_bubble;
  slot_op_e          skid_op;

  assign in_ready = !skid_valid & !bubble & !flush;

  // A held skid entry always goes to main first; a bubble is only made when skid is empty
  always_comb begin
    main_op        = SLOT_HOLD;
    skid_op        = SLOT_HOLD;
    main_ld_data   = skid_data;
    main_ld_ctrl   = skid_ctrl;
    main_ld_bubble = skid_bubble;
    if (flush) begin
      main_op = SLOT_CLEAR;
      skid_op = SLOT_CLEAR;
    end else if (advance) begin
      if (skid_valid) begin
        main_op = SLOT_LOAD;
        skid_op = SLOT_DROP;
      end else if (bubble) begin
        main_op = SLOT_KILL;
      end else if (in_fire) begin
        main_op        = SLOT_LOAD;
        main_ld_data   = in_data;
        main_ld_ctrl   = in_ctrl;
        main_ld_bubble = 1'b0;
      end else begin
        main_op = SLOT_DROP;
      end
    end else if (in_fire) begin
      skid_op = SLOT_LOAD;
    end
  end

  pipe_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .KILL_MASK (KILL_MASK)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (skid_op),
    .ld_data   (in_data),
    .ld_ctrl   (in_ctrl),
    .ld_bubble (1'b0),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl),
    .bubble    (skid_bubble)
  );
`else
  assign in_ready = advance & !bubble & !flush;

  always_comb begin
    main_op        = SLOT_HOLD;
    main_ld_data   = in_data;
    main_ld_ctrl   = in_ctrl;
    main_ld_bubble = 1'b0;
    if (flush) begin
      main_op = SLOT_CLEAR;
    end else if (advance) begin
      if (bubble) begin
        main_op = SLOT_KILL;
      end else if (in_fire) begin
        main_op = SLOT_LOAD;
      end else begin
        main_op = SLOT_DROP;
      end
    end
  end
`endif

  pipe_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .KILL_MASK (KILL_MASK)
  ) u_main (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (main_op),
    .ld_data   (main_ld_data),
    .ld_ctrl   (main_ld_ctrl),
    .ld_bubble (main_ld_bubble),
    .valid     (out_valid),
    .data      (out_data),
    .ctrl      (out_ctrl),
    .bubble    (out_bubble)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue model of the stage contents predicts
// ready/valid/payload each cycle, and a monitor retires expected entries on output transfers.
module tb_pipe_stage_reg;

  localparam int DATA_W = 16;
  localparam int CTRL_W = 8;
  localparam logic [CTRL_W-1:0] KILL_MASK = 8'h07;
`ifdef PIPE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic              bub;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset_n, flush, bubble, in_valid, in_ready, out_valid, out_ready, out_bubble;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;

  entry_t mdl_q[$];
  entry_t sb_q[$];
  entry_t held;
  int     vectors = 0;
  int     miscompares = 0;
  bit     known = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .KILL_MASK (KILL_MASK)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .bubble     (bubble),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_bubble (out_bubble)
  );

  // The stage is a FIFO of capacity CAP; without skid a full stage accepts only while popping
  function automatic bit mdlInReady();
    if (bubble || flush) return 1'b0;
    if (CAP == 2) return mdl_q.size() < 2;
    return (mdl_q.size() == 0) || out_ready;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    if (!known) return;
    compare("in_ready", 32'(in_ready), 32'(mdlInReady()));
    compare("out_valid", 32'(out_valid), 32'(mdl_q.size() > 0));
    compare("out_data", 32'(out_data), 32'(held.data));
    compare("out_ctrl", 32'(out_ctrl), 32'(held.ctrl));
    compare("out_bubble", 32'(out_bubble), 32'((mdl_q.size() > 0) && held.bub));
  endtask

  task automatic pushEntry(input entry_t e);
    mdl_q.push_back(e);
    sb_q.push_back(e);
  endtask

  task automatic updateModel(input logic rst, input logic fl, input logic bu, input logic iv,
                             input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                             input logic ordy);
    int     n;
    bit     adv;
    bit     fire;
    entry_t e;
    n    = mdl_q.size();
    adv  = (n == 0) || ordy;
    fire = iv && mdlInReady();
    if (!rst || fl) begin
      mdl_q.delete();
      sb_q.delete();
      held = '0;
      if (!rst) known = 1'b1;
    end else begin
      if (n > 0 && ordy) void'(mdl_q.pop_front());
      if (bu) begin
        if (adv && n < 2) begin
          e.data = held.data;
          e.ctrl = held.ctrl & ~KILL_MASK;
          e.bub  = 1'b1;
          pushEntry(e);
        end
      end else if (fire) begin
        e.data = d;
        e.ctrl = c;
        e.bub  = 1'b0;
        pushEntry(e);
      end
      if (mdl_q.size() > 0) held = mdl_q[0];
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic fl, input logic bu, input logic iv,
                               input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                               input logic ordy);
    reset_n   = rst;
    flush     = fl;
    bubble    = bu;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel(rst, fl, bu, iv, d, c, ordy);
    #1;
  endtask

  // Every output transfer must retire the oldest expected entry unchanged
  always @(negedge clk) begin
    entry_t e;
    if (known && reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        compare("sb_unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        compare("sb_data", 32'(out_data), 32'(e.data));
        compare("sb_ctrl", 32'(out_ctrl), 32'(e.ctrl));
        compare("sb_bubble", 32'(out_bubble), 32'(e.bub));
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, DATA_W'(16'hA000 + i), CTRL_W'($urandom), 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);

    $display("[TB] bubble insertion");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 8'h0F, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'hDEAD, 8'h33, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);

    $display("[TB] flush with pending entries");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 8'hF1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 8'hF2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h3333, 8'hF3, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);

    $display("[TB] backpressure and bubble with skid occupied");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h4444, 8'hA4, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 8'hA5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h6666, 8'hA6, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h7777, 8'hA7, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++)
      applyStimulus($urandom_range(99) != 0, $urandom_range(24) == 0, $urandom_range(7) == 0,
                    $urandom_range(2) != 0, DATA_W'($urandom), CTRL_W'($urandom),
                    $urandom_range(3) != 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
